// File: rtl/shell_counter_bank_pkg.sv
// Shared definitions for the shell counter bank: register offsets, control layout, mode enum.
package shell_counter_bank_pkg;

  // Word offsets within a channel block (4 words per channel).
  localparam logic [1:0] OFF_CTRL  = 2'd0;
  localparam logic [1:0] OFF_LIMIT = 2'd1;
  localparam logic [1:0] OFF_COUNT = 2'd2;
  localparam logic [1:0] OFF_SNAP  = 2'd3;

  // Word offsets within the global block that follows the last channel.
  localparam logic [1:0] OFF_STATUS    = 2'd0;
  localparam logic [1:0] OFF_SNAP_TRIG = 2'd1;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  typedef struct packed {
    logic [7:0] step;
    mode_e      mode;
    logic       enable;
  } ctrl_t;

  // Reset configuration: enabled free-running +1 counter.
  localparam ctrl_t CtrlRst = '{step: 8'd1, mode: MODE_WRAP, enable: 1'b1};

  // CTRL register image: [0] enable, [1] mode, [15:8] step.
  function automatic logic [31:0] ctrl_pack(input ctrl_t c);
    return {16'h0000, c.step, 6'b000000, c.mode, c.enable};
  endfunction

  function automatic ctrl_t ctrl_unpack(input logic [31:0] w);
    ctrl_t c;
    c.step   = w[15:8];
    c.mode   = mode_e'(w[1]);
    c.enable = w[0];
    return c;
  endfunction

endpackage

// File: rtl/shell_counter_ch.sv
// One counter channel: control, limit, count and sticky overflow with host write strobes.
module shell_counter_ch
  import shell_counter_bank_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ctrl_we_i,
  input  logic             limit_we_i,
  input  logic             count_we_i,
  input  logic             ovf_clr_i,
  input  logic [31:0]      wdata_i,
  output ctrl_t            ctrl_o,
  output logic [Width-1:0] limit_o,
  output logic [Width-1:0] count_o,
  output logic             ovf_o
);

  ctrl_t            ctrl_q, ctrl_d;
  logic [Width-1:0] limit_q, limit_d;
  logic [Width-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             inc_en;
  logic             over;
  logic             ovf_evt;
  logic [Width:0]   sum;

  // Next-state: host writes, increment with wrap/saturate, sticky overflow.
  always_comb begin
    ctrl_d  = ctrl_q;
    limit_d = limit_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (ctrl_we_i)  ctrl_d  = ctrl_unpack(wdata_i);
    if (limit_we_i) limit_d = wdata_i[Width-1:0];

    inc_en = ctrl_q.enable && (ctrl_q.step != 8'd0);
    // One extra bit so the carry out of count+step is visible to the limit compare.
    sum    = {1'b0, count_q} + (Width + 1)'(ctrl_q.step);
    over   = sum > {1'b0, limit_q};
    // A host COUNT write replaces this cycle's increment, including its overflow check.
    ovf_evt = inc_en && over && !count_we_i;

    if (count_we_i) begin
      count_d = wdata_i[Width-1:0];
    end else if (inc_en) begin
      if (over) begin
        count_d = (ctrl_q.mode == MODE_SAT) ? limit_q : '0;
      end else begin
        count_d = sum[Width-1:0];
      end
    end

    // Set has priority over a simultaneous write-1-to-clear.
    if (ovf_clr_i) ovf_d = 1'b0;
    if (ovf_evt)   ovf_d = 1'b1;
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q  <= CtrlRst;
      limit_q <= '1;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      limit_q <= limit_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ctrl_o  = ctrl_q;
  assign limit_o = limit_q;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/shell_counter_bank.sv
// Bank of NUM_CH counters behind a single-cycle register port.
// Optional feature macro: SHELL_CNT_SNAPSHOT_EN adds SNAP registers loaded by SNAP_TRIG.
module shell_counter_bank
  import shell_counter_bank_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = $clog2(NUM_CH + 1) + 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_W-1:0]       req_addr_i,
  input  logic [31:0]             req_wdata_i,
  output logic                    rsp_valid_o,
  output logic [31:0]             rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [NUM_CH*WIDTH-1:0] count_o,
  output logic [NUM_CH-1:0]       ovf_o
);

  localparam int unsigned ChW = ADDR_W - 2;
  localparam logic [ChW-1:0] GlobalSel = ChW'(NUM_CH);

  logic [ChW-1:0] chan_sel;
  logic [1:0]     reg_sel;
  logic           ch_hit;
  logic           glb_hit;
  logic           addr_err;
  logic           wr;
  logic           rd;

  logic [NUM_CH-1:0] ctrl_we, limit_we, count_we, ovf_clr;
  ctrl_t             ch_ctrl  [NUM_CH];
  logic [WIDTH-1:0]  ch_limit [NUM_CH];
  logic [WIDTH-1:0]  ch_count [NUM_CH];
  logic [WIDTH-1:0]  snap_val [NUM_CH];
  logic [NUM_CH-1:0] ch_ovf;

  logic [31:0] rdata_mux;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  assign req_ready_o = 1'b1;

  assign chan_sel = req_addr_i[ADDR_W-1:2];
  assign reg_sel  = req_addr_i[1:0];
  assign ch_hit   = chan_sel < GlobalSel;
  assign glb_hit  = chan_sel == GlobalSel;
  // SNAP_TRIG decodes even when snapshots are compiled out; it is simply inert then.
  assign addr_err = !(ch_hit ||
                      (glb_hit && ((reg_sel == OFF_STATUS) || (reg_sel == OFF_SNAP_TRIG))));
  assign wr       = req_valid_i && req_we_i && !addr_err;
  assign rd       = req_valid_i && !req_we_i && !addr_err;

  // Per-channel write strobes and STATUS write-1-to-clear.
  always_comb begin
    ctrl_we  = '0;
    limit_we = '0;
    count_we = '0;
    ovf_clr  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr && (chan_sel == ChW'(c))) begin
        ctrl_we[c]  = reg_sel == OFF_CTRL;
        limit_we[c] = reg_sel == OFF_LIMIT;
        count_we[c] = reg_sel == OFF_COUNT;
      end
      ovf_clr[c] = wr && glb_hit && (reg_sel == OFF_STATUS) && req_wdata_i[c];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    shell_counter_ch #(
      .Width(WIDTH)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .ctrl_we_i (ctrl_we[c]),
      .limit_we_i(limit_we[c]),
      .count_we_i(count_we[c]),
      .ovf_clr_i (ovf_clr[c]),
      .wdata_i   (req_wdata_i),
      .ctrl_o    (ch_ctrl[c]),
      .limit_o   (ch_limit[c]),
      .count_o   (ch_count[c]),
      .ovf_o     (ch_ovf[c])
    );
    assign count_o[c*WIDTH +: WIDTH] = ch_count[c];
  end

  assign ovf_o = ch_ovf;

`ifdef SHELL_CNT_SNAPSHOT_EN
  logic             snap_trig_we;
  logic [WIDTH-1:0] snap_q [NUM_CH];
  logic [WIDTH-1:0] snap_d [NUM_CH];

  assign snap_trig_we = wr && glb_hit && (reg_sel == OFF_SNAP_TRIG);

  // Capture all pre-update counts together on a SNAP_TRIG write.
  always_comb begin
    snap_d = snap_q;
    if (snap_trig_we) begin
      for (int c = 0; c < NUM_CH; c++) snap_d[c] = ch_count[c];
    end
  end

  // Snapshot registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) snap_q[c] <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end

  assign snap_val = snap_q;
`else
  assign snap_val = '{default: '0};
`endif

  // Read data as registers stand in the accept cycle; zero for writes and errors.
  always_comb begin
    rdata_mux = '0;
    if (rd) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (chan_sel == ChW'(c)) begin
          unique case (reg_sel)
            OFF_CTRL:  rdata_mux = ctrl_pack(ch_ctrl[c]);
            OFF_LIMIT: rdata_mux = 32'(ch_limit[c]);
            OFF_COUNT: rdata_mux = 32'(ch_count[c]);
            OFF_SNAP:  rdata_mux = 32'(snap_val[c]);
            default:   rdata_mux = '0;
          endcase
        end
      end
      if (glb_hit && (reg_sel == OFF_STATUS)) rdata_mux = 32'(ch_ovf);
    end
  end

  // Response is a one-cycle strobe following every accepted request.
  always_comb begin
    rsp_valid_d = req_valid_i;
    rsp_err_d   = req_valid_i && addr_err;
    rsp_rdata_d = rdata_mux;
  end

  // Response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule
